irq_responder_10: RTL and testbench
===================================

IRQ_RESPONDER_10 -- requirements
Module: irq_responder_10

Interface
REQ-001 The block SHALL have parameter BubblesMask, default 10'h000, where bit i set inverts Input_(i+1) before use.
REQ-002 The block SHALL have parameter EdgeMask, default 10'h3FF, where bit i set makes source i+1 edge-triggered and clear makes it level-triggered.
REQ-003 Clock  in  1  the single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 Input_1..Input_10  in  1 each  request lines, synchronous to Clock, no internal synchronizer; Input_1 has highest priority.
REQ-006 Enable_We  in  1  write strobe for the enable register.
REQ-007 Enable_Data  in  10  new enable value; bit i gates source i+1.
REQ-008 Ack  in  1  responder acknowledge pulse from the CPU.
REQ-009 Eoi  in  1  end-of-interrupt pulse from the CPU.
REQ-010 Irq  out  1  registered interrupt request to the CPU.
REQ-011 Irq_Id  out  4  source number 1..10; 0 means none.
REQ-012 In_Service  out  1  high while an acknowledged interrupt is being serviced.
REQ-013 Pending  out  10  the raw pending register.

Function
REQ-014 Real input i SHALL be Input_(i+1) XOR BubblesMask[i]; Prev[i] SHALL register the real input every cycle.
REQ-015 For an edge source, Pending[i] SHALL set at the edge where the real input is 1 and Prev[i] is 0, and SHALL clear only on acknowledge.
REQ-016 For a level source, Pending[i] SHALL equal the real input registered one cycle; acknowledge SHALL NOT clear it.
REQ-017 Enable SHALL load Enable_Data on a clock edge with Enable_We high, effective the following cycle; Eligible = Pending AND Enable.
REQ-018 States SHALL be IDLE, REQUEST and SERVICE.
REQ-019 From IDLE, the block SHALL go to REQUEST when Eligible is nonzero.
REQ-020 In REQUEST, Irq=1 and Irq_Id SHALL be the lowest-indexed Eligible source plus 1, re-evaluated every cycle so a higher-priority arrival preempts the ID.
REQ-021 In REQUEST with Eligible zero (level dropped or source disabled), the block SHALL return to IDLE with no acknowledge required (spurious).
REQ-022 Ack in REQUEST SHALL latch the current Irq_Id, clear that Pending bit if it is an edge source, and go to SERVICE.
REQ-023 In SERVICE, Irq=0, In_Service=1 and Irq_Id SHALL hold the latched value; nesting is not supported.
REQ-024 Eoi in SERVICE SHALL go to IDLE; Irq_Id=0 and In_Service=0 in IDLE.
REQ-025 Ack outside REQUEST and Eoi outside SERVICE SHALL be ignored.
REQ-026 Ack and Eoi together in REQUEST SHALL be treated as Ack only.
REQ-027 A new edge on the same bit in the cycle it is cleared by Ack SHALL leave Pending set (set wins).
REQ-028 Edges arriving in any state SHALL be recorded in Pending and never lost; repeated edges before service SHALL collapse to one.
REQ-029 Latency SHALL be: real input rises at edge N, Pending set at N+1, Irq high after N+2.
REQ-030 Irq, In_Service and Irq_Id SHALL be driven from registers and state only (glitch-free).

Reset
REQ-031 On Reset assertion, the block SHALL clear state to IDLE and zero Pending, Enable, Prev, the latched ID, Irq, Irq_Id and In_Service immediately, without waiting for Clock.
REQ-032 Reset mid-SERVICE or mid-REQUEST SHALL discard the interrupt; no Eoi is required afterwards.
REQ-033 Because Prev resets to 0, an edge source whose real input is 1 at reset release SHALL register one pending edge.

Verification
REQ-034 Enable=3FF, pulse Input_3 -> Pending[2]=1 next edge; Irq=1, Irq_Id=3 one cycle later; Ack -> Irq=0, In_Service=1, Pending[2]=0; Eoi -> Irq_Id=0.
REQ-035 Input_7 pending in REQUEST, then Input_2 edge before Ack -> Irq_Id changes 7->2; Ack services 2; after Eoi, Irq reasserts with Irq_Id=7.
REQ-036 Level source 5 (EdgeMask[4]=0) high -> Irq_Id=5; drop it before Ack -> Irq falls, state IDLE, no Ack needed.
REQ-037 BubblesMask[0]=1, Input_1 held 0 through reset release -> exactly one interrupt with Irq_Id=1; Enable=0 -> no Irq while Pending[0]=1.
REQ-038 Ack and Eoi together in REQUEST -> SERVICE entered; Reset asserted in SERVICE -> In_Service=0, Pending=0 asynchronously.

Source files
------------

// File: rtl/irq_responder_10.sv
// Ten-source prioritised interrupt responder: edge/level capture, enable gating,
// and an IDLE -> REQUEST -> SERVICE handshake with the CPU via Ack and Eoi.
module irq_responder_10 #(
  parameter logic [9:0] BubblesMask = 10'h000,
  parameter logic [9:0] EdgeMask    = 10'h3FF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Input_1,
  input  logic       Input_2,
  input  logic       Input_3,
  input  logic       Input_4,
  input  logic       Input_5,
  input  logic       Input_6,
  input  logic       Input_7,
  input  logic       Input_8,
  input  logic       Input_9,
  input  logic       Input_10,
  input  logic       Enable_We,
  input  logic [9:0] Enable_Data,
  input  logic       Ack,
  input  logic       Eoi,
  output logic       Irq,
  output logic [3:0] Irq_Id,
  output logic       In_Service,
  output logic [9:0] Pending,
  output logic [1:0] Fsm_State
);

  // Handshake: Irq stays high in REQUEST until a one-cycle Ack pulse is seen
  // on a rising Clock edge; Eoi is a one-cycle pulse honoured only in SERVICE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state, next_state;
  logic [9:0] real_in;
  logic [9:0] prev;
  logic [9:0] enable;
  logic [9:0] eligible;
  logic [9:0] ack_clear;
  logic [9:0] pending_next;
  logic [3:0] prio_id;
  logic [3:0] latched_id;
  logic [3:0] latched_next;
  logic [3:0] irq_id_next;
  logic       take_ack;

  assign real_in = {Input_10, Input_9, Input_8, Input_7, Input_6,
                    Input_5, Input_4, Input_3, Input_2, Input_1} ^ BubblesMask;
  assign eligible  = Pending & enable;
  assign take_ack  = (state == REQUEST) && Ack;
  assign Fsm_State = state;

  // Lowest-indexed eligible source wins; scanning downward lets it overwrite.
  always_comb begin
    prio_id = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (eligible[i]) prio_id = 4'(i + 1);
    end
  end

  always_comb begin
    ack_clear = '0;
    for (int i = 0; i < 10; i++) begin
      ack_clear[i] = take_ack && (Irq_Id == 4'(i + 1)) && EdgeMask[i];
    end
  end

  // A fresh edge is ORed in after the ack clear, so set wins over clear.
  assign pending_next = (EdgeMask & ((real_in & ~prev) | (Pending & ~ack_clear)))
                      | (~EdgeMask & real_in);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (eligible != '0) next_state = REQUEST;
      REQUEST: begin
        if (Ack)                   next_state = SERVICE;
        else if (eligible == '0)   next_state = IDLE;
      end
      SERVICE: if (Eoi)            next_state = IDLE;
      default:                     next_state = IDLE;
    endcase
  end

  always_comb begin
    latched_next = take_ack ? Irq_Id : latched_id;
    irq_id_next  = 4'd0;
    case (next_state)
      REQUEST: irq_id_next = prio_id;
      SERVICE: irq_id_next = latched_next;
      default: irq_id_next = 4'd0;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      prev       <= '0;
      enable     <= '0;
      Pending    <= '0;
      latched_id <= 4'd0;
      Irq        <= 1'b0;
      Irq_Id     <= 4'd0;
      In_Service <= 1'b0;
    end else begin
      state      <= next_state;
      prev       <= real_in;
      Pending    <= pending_next;
      latched_id <= latched_next;
      if (Enable_We) enable <= Enable_Data;
      Irq        <= (next_state == REQUEST);
      Irq_Id     <= irq_id_next;
      In_Service <= (next_state == SERVICE);
    end
  end

endmodule

// File: tb/tb_irq_responder_10.sv
// Directed bench for irq_responder_10: source 1 inverted, source 5 level-triggered,
// all others edge-triggered; expectations are hand-derived cycle by cycle.
module tb_irq_responder_10;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQUEST = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] in_v = '0;
  logic       Enable_We = 1'b0;
  logic [9:0] Enable_Data = '0;
  logic       Ack = 1'b0;
  logic       Eoi = 1'b0;
  logic       Irq;
  logic [3:0] Irq_Id;
  logic       In_Service;
  logic [9:0] Pending;
  logic [1:0] Fsm_State;

  int n_checks = 0;
  int n_errors = 0;

  irq_responder_10 #(.BubblesMask(10'h001), .EdgeMask(10'h3EF)) dut (
    .Clock(Clock), .Reset(Reset),
    .Input_1(in_v[0]), .Input_2(in_v[1]), .Input_3(in_v[2]), .Input_4(in_v[3]),
    .Input_5(in_v[4]), .Input_6(in_v[5]), .Input_7(in_v[6]), .Input_8(in_v[7]),
    .Input_9(in_v[8]), .Input_10(in_v[9]),
    .Enable_We(Enable_We), .Enable_Data(Enable_Data), .Ack(Ack), .Eoi(Eoi),
    .Irq(Irq), .Irq_Id(Irq_Id), .In_Service(In_Service), .Pending(Pending),
    .Fsm_State(Fsm_State)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_ack();
    Ack = 1'b1; tick(); Ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    Eoi = 1'b1; tick(); Eoi = 1'b0;
  endtask

  task automatic pulse_in(input int idx);
    in_v[idx] = 1'b1; tick(); in_v[idx] = 1'b0;
  endtask

  initial begin
    // Reset state; Input_1 held low so its inverted real input is 1
    tick(); tick();
    check("rst_irq", 16'(Irq), 16'h0);
    check("rst_id", 16'(Irq_Id), 16'h0);
    check("rst_insvc", 16'(In_Service), 16'h0);
    check("rst_pend", 16'(Pending), 16'h0);
    check("rst_state", 16'(Fsm_State), 16'(S_IDLE));

    // Inverted source 1 registers one edge after release; disabled -> no Irq
    Reset = 1'b0;
    tick();
    check("bub_pend", 16'(Pending), 16'h001);
    check("bub_noirq0", 16'(Irq), 16'h0);
    tick(); tick();
    check("bub_noirq1", 16'(Irq), 16'h0);
    check("bub_pend_hold", 16'(Pending), 16'h001);
    Enable_We = 1'b1; Enable_Data = 10'h3FF;
    tick();
    Enable_We = 1'b0;
    check("en_delay", 16'(Irq), 16'h0);
    tick();
    check("bub_irq", 16'(Irq), 16'h1);
    check("bub_id", 16'(Irq_Id), 16'h1);
    pulse_ack();
    check("bub_svc", 16'(Fsm_State), 16'(S_SERVICE));
    check("bub_ack_clr", 16'(Pending), 16'h000);
    pulse_eoi();
    check("bub_eoi", 16'(Fsm_State), 16'(S_IDLE));
    tick(); tick(); tick();
    check("bub_once", 16'(Irq), 16'h0);

    // Ack in IDLE is ignored
    pulse_ack();
    check("ack_idle", 16'(Fsm_State), 16'(S_IDLE));

    // Basic edge flow and latency on source 3
    pulse_in(2);
    check("e3_pend", 16'(Pending), 16'h004);
    check("e3_lat", 16'(Irq), 16'h0);
    tick();
    check("e3_irq", 16'(Irq), 16'h1);
    check("e3_id", 16'(Irq_Id), 16'h3);
    pulse_ack();
    check("e3_ack_irq", 16'(Irq), 16'h0);
    check("e3_ack_svc", 16'(In_Service), 16'h1);
    check("e3_ack_pend", 16'(Pending), 16'h000);
    check("e3_ack_id", 16'(Irq_Id), 16'h3);
    pulse_eoi();
    check("e3_eoi_id", 16'(Irq_Id), 16'h0);
    check("e3_eoi_svc", 16'(In_Service), 16'h0);

    // Preemption: source 7 requesting, source 2 arrives before Ack
    pulse_in(6);
    tick();
    check("pre_id7", 16'(Irq_Id), 16'h7);
    pulse_eoi();
    check("eoi_req_ign", 16'(Fsm_State), 16'(S_REQUEST));
    pulse_in(1);
    check("pre_id7_hold", 16'(Irq_Id), 16'h7);
    tick();
    check("pre_id2", 16'(Irq_Id), 16'h2);
    pulse_ack();
    check("pre_svc_id", 16'(Irq_Id), 16'h2);
    check("pre_svc_pend", 16'(Pending), 16'h040);
    pulse_eoi();
    check("pre_idle", 16'(Fsm_State), 16'(S_IDLE));
    tick();
    check("pre_re_irq", 16'(Irq), 16'h1);
    check("pre_re_id", 16'(Irq_Id), 16'h7);
    pulse_ack();
    pulse_eoi();
    check("pre_clean", 16'(Pending), 16'h000);

    // Level source 5 dropped before Ack -> spurious return to IDLE
    in_v[4] = 1'b1;
    tick();
    check("lvl_pend", 16'(Pending), 16'h010);
    tick();
    check("lvl_irq", 16'(Irq), 16'h1);
    check("lvl_id", 16'(Irq_Id), 16'h5);
    in_v[4] = 1'b0;
    tick();
    check("lvl_drop_pend", 16'(Pending), 16'h000);
    tick();
    check("lvl_spur_irq", 16'(Irq), 16'h0);
    check("lvl_spur_state", 16'(Fsm_State), 16'(S_IDLE));
    check("lvl_spur_id", 16'(Irq_Id), 16'h0);

    // New edge in the Ack cycle keeps the pending bit
    pulse_in(2);
    tick();
    check("sw_id", 16'(Irq_Id), 16'h3);
    in_v[2] = 1'b1; Ack = 1'b1;
    tick();
    in_v[2] = 1'b0; Ack = 1'b0;
    check("sw_pend", 16'(Pending), 16'h004);
    check("sw_state", 16'(Fsm_State), 16'(S_SERVICE));
    pulse_eoi();
    tick();
    check("sw_re_id", 16'(Irq_Id), 16'h3);

    // Ack and Eoi together in REQUEST act as Ack
    Ack = 1'b1; Eoi = 1'b1;
    tick();
    Ack = 1'b0; Eoi = 1'b0;
    check("ae_state", 16'(Fsm_State), 16'(S_SERVICE));
    check("ae_insvc", 16'(In_Service), 16'h1);
    pulse_in(5);
    check("svc_edge_pend", 16'(Pending), 16'h020);
    pulse_in(5);
    check("svc_collapse", 16'(Pending), 16'h020);

    // Asynchronous reset while in SERVICE
    #2 Reset = 1'b1;
    #1;
    check("ar_insvc", 16'(In_Service), 16'h0);
    check("ar_pend", 16'(Pending), 16'h000);
    check("ar_state", 16'(Fsm_State), 16'(S_IDLE));
    check("ar_id", 16'(Irq_Id), 16'h0);
    tick();
    Reset = 1'b0;
    tick(); tick(); tick();
    check("post_rst_noirq", 16'(Irq), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
